// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module     : imem_loader_pkg
// Description: Shared state encoding and defaults for the instruction loader.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } loader_state_e;

    localparam logic [7:0]  LOADER_MAGIC       = 8'hA5;
    localparam int unsigned LOADER_DEPTH_WORDS = 2048;

endpackage

`default_nettype wire

// File: rtl/imem_word_packer.sv
// ============================================================================
// Module     : imem_word_packer
// Description: Packs a byte stream little-endian into 32-bit words.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_byte,
    input  logic        i_strobe,
    input  logic        i_clear,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic [1:0]  o_byte_idx
);

    logic [1:0]  r_idx;
    logic [31:0] r_word;
    logic        r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= 2'd0;
            r_word  <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            // Pulse lands in the cycle after the fourth byte is captured.
            r_valid <= i_strobe && !i_clear && (r_idx == 2'd3);
            if (i_clear) begin
                r_idx <= 2'd0;
            end else if (i_strobe) begin
                r_word[{r_idx, 3'b000} +: 8] <= i_byte;
                r_idx                        <= r_idx + 2'd1;
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_valid;
    assign o_byte_idx   = r_idx;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module     : imem_loader
// Description: Framed UART boot loader writing the instruction RAM.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = LOADER_DEPTH_WORDS,
    parameter logic [7:0]  MAGIC       = LOADER_MAGIC,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_ready,
    output logic        o_mem_we,
    output logic [31:0] o_mem_waddr,
    output logic [31:0] o_mem_wdata,
    output logic        o_cpu_rst_n,
    output logic        o_load_done,
    output logic        o_load_err
);

    loader_state_e r_state;
    loader_state_e w_next;

    logic        r_rx_ready;
    logic [15:0] r_len;
    logic [15:0] r_word_idx;
    logic [7:0]  r_xor;
    logic [31:0] r_idle;
    logic [31:0] r_waddr;
    logic        r_done;
    logic        r_err;
    logic        r_cpu_rst_n;

    logic        w_accept;
    logic        w_in_frame;
    logic        w_timeout;
    logic        w_restart;
    logic        w_data_byte;
    logic        w_word_done;
    logic        w_last_word;
    logic [15:0] w_len_full;
    logic [1:0]  w_byte_idx;

    assign w_accept    = i_rx_valid && r_rx_ready;
    assign w_in_frame  = (r_state == LEN0) || (r_state == LEN1) ||
                         (r_state == DATA) || (r_state == CSUM);
    assign w_timeout   = w_in_frame && (r_idle >= TIMEOUT_CYC);
    assign w_restart   = w_accept && (i_rx_data == MAGIC) &&
                         ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
    assign w_data_byte = w_accept && (r_state == DATA) && !w_timeout;
    assign w_word_done = w_data_byte && (w_byte_idx == 2'd3);
    assign w_last_word = w_word_done && ((r_word_idx + 16'd1) == r_len);
    assign w_len_full  = {i_rx_data, r_len[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (w_restart) w_next = LEN0;
            end
            LEN0: begin
                if (w_accept) w_next = LEN1;
            end
            LEN1: begin
                if (w_accept) begin
                    if ({16'd0, w_len_full} > DEPTH_WORDS) w_next = ERR;
                    else if (w_len_full == 16'd0)          w_next = CSUM;
                    else                                   w_next = DATA;
                end
            end
            DATA: begin
                if (w_last_word) w_next = CSUM;
            end
            CSUM: begin
                if (w_accept) w_next = (i_rx_data == r_xor) ? DONE : ERR;
            end
            default: w_next = IDLE;
        endcase
        // A stalled frame is abandoned even if a byte shows up on the limit cycle.
        if (w_timeout) w_next = ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ready  <= 1'b0;
            r_len       <= 16'd0;
            r_word_idx  <= 16'd0;
            r_xor       <= 8'd0;
            r_idle      <= 32'd0;
            r_waddr     <= 32'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_rx_ready <= 1'b1;
            r_idle     <= (w_in_frame && !w_accept && !w_timeout) ? r_idle + 32'd1 : 32'd0;
            if (w_restart) begin
                r_len      <= 16'd0;
                r_word_idx <= 16'd0;
                r_xor      <= 8'd0;
            end else begin
                if (w_accept && !w_timeout && (r_state == LEN0)) r_len[7:0]  <= i_rx_data;
                if (w_accept && !w_timeout && (r_state == LEN1)) r_len[15:8] <= i_rx_data;
                if (w_data_byte) r_xor <= r_xor ^ i_rx_data;
                if (w_word_done) begin
                    r_waddr    <= {14'd0, r_word_idx, 2'b00};
                    r_word_idx <= r_word_idx + 16'd1;
                end
            end
            r_done      <= (w_next == DONE);
            r_err       <= (w_next == ERR);
            r_cpu_rst_n <= (w_next == DONE);
        end
    end

    imem_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_byte       (i_rx_data),
        .i_strobe     (w_data_byte),
        .i_clear      (w_restart),
        .o_word       (o_mem_wdata),
        .o_word_valid (o_mem_we),
        .o_byte_idx   (w_byte_idx)
    );

    assign o_rx_ready  = r_rx_ready;
    assign o_mem_waddr = r_waddr;
    assign o_cpu_rst_n = r_cpu_rst_n;
    assign o_load_done = r_done;
    assign o_load_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module     : tb_imem_loader
// Description: Directed self-checking bench for imem_loader.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data = 8'd0;
    logic        o_rx_ready;
    logic        o_mem_we;
    logic [31:0] o_mem_waddr;
    logic [31:0] o_mem_wdata;
    logic        o_cpu_rst_n;
    logic        o_load_done;
    logic        o_load_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] wa [32];
    logic [31:0] wd [32];
    int          wn = 0;
    int          base;
    logic [7:0]  tx_q [$];

    always #5 clk = ~clk;

    imem_loader #(
        .DEPTH_WORDS (2048),
        .MAGIC       (8'hA5),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx_valid  (i_rx_valid),
        .i_rx_data   (i_rx_data),
        .o_rx_ready  (o_rx_ready),
        .o_mem_we    (o_mem_we),
        .o_mem_waddr (o_mem_waddr),
        .o_mem_wdata (o_mem_wdata),
        .o_cpu_rst_n (o_cpu_rst_n),
        .o_load_done (o_load_done),
        .o_load_err  (o_load_err)
    );

    // Memory-write monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (o_mem_we === 1'b1 && wn < 32) begin
            wa[wn] = o_mem_waddr;
            wd[wn] = o_mem_wdata;
            wn     = wn + 1;
        end
    end

    task automatic send_q();
        foreach (tx_q[i]) begin
            i_rx_valid = 1'b1;
            i_rx_data  = tx_q[i];
            @(negedge clk);
        end
        i_rx_valid = 1'b0;
    endtask

    task automatic step(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        checks++; if (o_rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", o_rx_ready); end
        checks++; if (o_mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", o_mem_we); end
        checks++; if (o_mem_waddr !== 32'd0 || o_mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", o_mem_waddr, o_mem_wdata); end
        checks++; if ({o_cpu_rst_n, o_load_done, o_load_err} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {o_cpu_rst_n, o_load_done, o_load_err}); end
        rst_n = 1'b1;
        idle(2);
        checks++; if (o_rx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", o_rx_ready); end
    endtask

    task automatic test_two_words();
        base = wn;
        // XOR of the eight data bytes is 0x88.
        tx_q = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        send_q();
        idle(2);
        checks++; if (wn - base !== 2) begin errors++; $display("FAIL two_words_count: got %0d want 2", wn - base); end
        checks++; if (wa[base] !== 32'h0 || wd[base] !== 32'h44332211) begin errors++; $display("FAIL two_words_w0: got %h/%h want 0/44332211", wa[base], wd[base]); end
        checks++; if (wa[base+1] !== 32'h4 || wd[base+1] !== 32'h88776655) begin errors++; $display("FAIL two_words_w1: got %h/%h want 4/88776655", wa[base+1], wd[base+1]); end
        checks++; if ({o_cpu_rst_n, o_load_done, o_load_err} !== 3'b110) begin errors++; $display("FAIL two_words_status: got %b want 110", {o_cpu_rst_n, o_load_done, o_load_err}); end
    endtask

    task automatic test_bad_csum();
        base = wn;
        step(8'hA5); step(8'h01); step(8'h00);
        checks++; if (o_load_done !== 1'b0 || o_cpu_rst_n !== 1'b0) begin errors++; $display("FAIL restart_clears_done: got done=%b cpu=%b want 0/0", o_load_done, o_cpu_rst_n); end
        step(8'hDE); step(8'hAD); step(8'hBE);
        checks++; if (o_mem_we !== 1'b0) begin errors++; $display("FAIL early_we: got %b want 0", o_mem_we); end
        step(8'hEF);
        checks++; if (o_mem_we !== 1'b1 || o_mem_waddr !== 32'h0 || o_mem_wdata !== 32'hEFBEADDE) begin errors++; $display("FAIL latency_write: got we=%b %h/%h want 1 0/efbeadde", o_mem_we, o_mem_waddr, o_mem_wdata); end
        step(8'h00);
        checks++; if (o_mem_we !== 1'b0) begin errors++; $display("FAIL we_single_pulse: got %b want 0", o_mem_we); end
        i_rx_valid = 1'b0;
        idle(2);
        checks++; if (wn - base !== 1) begin errors++; $display("FAIL bad_csum_count: got %0d want 1", wn - base); end
        checks++; if ({o_cpu_rst_n, o_load_done, o_load_err} !== 3'b001) begin errors++; $display("FAIL bad_csum_status: got %b want 001", {o_cpu_rst_n, o_load_done, o_load_err}); end
    endtask

    task automatic test_len_too_big();
        base = wn;
        tx_q = {8'hA5, 8'h01, 8'h08};
        send_q();
        checks++; if (o_load_err !== 1'b1) begin errors++; $display("FAIL len_big_err: got %b want 1", o_load_err); end
        tx_q = {8'h11, 8'h22, 8'h33, 8'h44};
        send_q();
        idle(2);
        checks++; if (wn - base !== 0) begin errors++; $display("FAIL len_big_writes: got %0d want 0", wn - base); end
        checks++; if ({o_cpu_rst_n, o_load_done, o_load_err} !== 3'b001) begin errors++; $display("FAIL len_big_status: got %b want 001", {o_cpu_rst_n, o_load_done, o_load_err}); end
    endtask

    task automatic test_len_zero();
        base = wn;
        tx_q = {8'h00, 8'hFF};
        send_q();
        checks++; if (o_load_err !== 1'b1) begin errors++; $display("FAIL junk_keeps_err: got %b want 1", o_load_err); end
        tx_q = {8'hA5, 8'h00, 8'h00, 8'h00};
        send_q();
        idle(2);
        checks++; if (wn - base !== 0) begin errors++; $display("FAIL len_zero_writes: got %0d want 0", wn - base); end
        checks++; if ({o_cpu_rst_n, o_load_done, o_load_err} !== 3'b110) begin errors++; $display("FAIL len_zero_status: got %b want 110", {o_cpu_rst_n, o_load_done, o_load_err}); end
    endtask

    task automatic test_timeout();
        base = wn;
        tx_q = {8'hA5, 8'h01, 8'h00, 8'h11};
        send_q();
        idle(10);
        checks++; if (o_load_err !== 1'b0 || o_load_done !== 1'b0) begin errors++; $display("FAIL timeout_early: got err=%b done=%b want 0/0", o_load_err, o_load_done); end
        idle(10);
        checks++; if ({o_cpu_rst_n, o_load_done, o_load_err} !== 3'b001) begin errors++; $display("FAIL timeout_status: got %b want 001", {o_cpu_rst_n, o_load_done, o_load_err}); end
        checks++; if (wn - base !== 0) begin errors++; $display("FAIL timeout_writes: got %0d want 0", wn - base); end
        tx_q = {8'hA5};
        send_q();
        idle(1);
        checks++; if (o_load_err !== 1'b0) begin errors++; $display("FAIL timeout_restart_clear: got %b want 0", o_load_err); end
        tx_q = {8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_q();
        idle(2);
        checks++; if (wn - base !== 1 || wa[base] !== 32'h0 || wd[base] !== 32'h04030201) begin errors++; $display("FAIL timeout_reload_write: got n=%0d %h/%h want 1 0/04030201", wn - base, wa[base], wd[base]); end
        checks++; if ({o_cpu_rst_n, o_load_done, o_load_err} !== 3'b110) begin errors++; $display("FAIL timeout_reload_status: got %b want 110", {o_cpu_rst_n, o_load_done, o_load_err}); end
    endtask

    task automatic test_reset_mid_frame();
        tx_q = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_q();
        rst_n = 1'b0;
        #1;
        checks++; if (o_rx_ready !== 1'b0 || o_mem_we !== 1'b0) begin errors++; $display("FAIL async_ready_we: got %b/%b want 0/0", o_rx_ready, o_mem_we); end
        checks++; if (o_mem_waddr !== 32'd0 || o_mem_wdata !== 32'd0) begin errors++; $display("FAIL async_addr_data: got %h/%h want 0/0", o_mem_waddr, o_mem_wdata); end
        checks++; if ({o_cpu_rst_n, o_load_done, o_load_err} !== 3'b000) begin errors++; $display("FAIL async_status: got %b want 000", {o_cpu_rst_n, o_load_done, o_load_err}); end
        idle(2);
        rst_n = 1'b1;
        idle(2);
        base = wn;
        tx_q = {8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        send_q();
        idle(2);
        checks++; if (wn - base !== 1 || wa[base] !== 32'h0 || wd[base] !== 32'hDDCCBBAA) begin errors++; $display("FAIL post_reset_write: got n=%0d %h/%h want 1 0/ddccbbaa", wn - base, wa[base], wd[base]); end
        checks++; if ({o_cpu_rst_n, o_load_done, o_load_err} !== 3'b110) begin errors++; $display("FAIL post_reset_status: got %b want 110", {o_cpu_rst_n, o_load_done, o_load_err}); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_two_words();
        test_bad_csum();
        test_len_too_big();
        test_len_zero();
        test_timeout();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
